// File: rtl/turbo_encoder_tx_if.sv
// Block input handshake and serial encoded output of the turbo encoder.
// The master side feeds info bits and observes the stream; the slave side is the encoder.
interface turbo_encoder_tx_if;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic block_start;
  logic block_end;

  modport master (
    output in_bit, in_valid,
    input  in_ready, out_bit, out_valid, block_start, block_end
  );

  modport slave (
    input  in_bit, in_valid,
    output in_ready, out_bit, out_valid, block_start, block_end
  );
endinterface

// File: rtl/turbo_encoder_tx.sv
// Rate-1/3 turbo encoder: buffers K info bits, then streams sys/p1/p2 triplets
// from two RSC(7,5) encoders (RSC2 fed through a step interleaver), one bit per clock.
module turbo_encoder_tx #(
  parameter int unsigned K        = 8,
  parameter int unsigned ILV_STEP = 3
) (
  input logic             clk,
  input logic             rst,
  turbo_encoder_tx_if.slave bus
);
  localparam int unsigned  IW     = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned  JW     = IW + 1;
  localparam logic [IW-1:0] LAST_I = IW'(K - 1);
  localparam logic [JW-1:0] K_J    = JW'(K);
  localparam logic [JW-1:0] STEP_J = JW'(ILV_STEP);

  typedef enum logic [1:0] {FILL, ENC, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [K-1:0]    info_buf_q, info_buf_d;
  logic [IW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [1:0]      ph_q, ph_d;
  logic [1:0]      s1_q, s1_d, s2_q, s2_d;
  logic            p1_q, p1_d, p2_q, p2_d;
  logic            in_ready_q, in_ready_d;
  logic            out_bit_q, out_bit_d;
  logic            out_valid_q, out_valid_d;
  logic            block_start_q, block_start_d;
  logic            block_end_q, block_end_d;
  logic [2:0]      r1, r2;
  logic [JW-1:0]   j_sum;

  // One RSC(7,5) step: returns {parity, next s1, next s0}.
  function automatic logic [2:0] rsc_step(input logic [1:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {a ^ s[0], a, s[1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      info_buf_q    <= '0;
      wr_cnt_q      <= '0;
      i_q           <= '0;
      j_q           <= '0;
      ph_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      p1_q          <= 1'b0;
      p2_q          <= 1'b0;
      in_ready_q    <= 1'b1;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      block_start_q <= 1'b0;
      block_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      info_buf_q    <= info_buf_d;
      wr_cnt_q      <= wr_cnt_d;
      i_q           <= i_d;
      j_q           <= j_d;
      ph_q          <= ph_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      in_ready_q    <= in_ready_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      block_start_q <= block_start_d;
      block_end_q   <= block_end_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    info_buf_d    = info_buf_q;
    wr_cnt_d      = wr_cnt_q;
    i_d           = i_q;
    j_d           = j_q;
    ph_d          = ph_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    in_ready_d    = in_ready_q;
    out_bit_d     = 1'b0;
    out_valid_d   = 1'b0;
    block_start_d = 1'b0;
    block_end_d   = 1'b0;
    r1            = rsc_step(s1_q, info_buf_q[i_q]);
    r2            = rsc_step(s2_q, info_buf_q[j_q]);
    j_sum         = JW'(j_q) + STEP_J;
    if (j_sum >= K_J) j_sum = j_sum - K_J;

    case (state_q)
      FILL: begin
        if (bus.in_valid && in_ready_q) begin
          info_buf_d[wr_cnt_q] = bus.in_bit;
          if (wr_cnt_q == LAST_I) begin
            wr_cnt_d   = '0;
            in_ready_d = 1'b0;
            state_d    = ENC;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      ENC: begin
        out_valid_d = 1'b1;
        case (ph_q)
          2'd0: begin
            out_bit_d     = info_buf_q[i_q];
            block_start_d = (i_q == '0);
            p1_d          = r1[2];
            p2_d          = r2[2];
            s1_d          = r1[1:0];
            s2_d          = r2[1:0];
            ph_d          = 2'd1;
          end
          2'd1: begin
            out_bit_d = p1_q;
            ph_d      = 2'd2;
          end
          default: begin
            out_bit_d = p2_q;
            ph_d      = 2'd0;
            // Last triplet: clear the encoders so the next block starts from state 00.
            if (i_q == LAST_I) begin
              block_end_d = 1'b1;
              i_d         = '0;
              j_d         = '0;
              s1_d        = '0;
              s2_d        = '0;
              state_d     = FLUSH;
            end else begin
              i_d = i_q + 1'b1;
              j_d = IW'(j_sum);
            end
          end
        endcase
      end
      FLUSH: begin
        in_ready_d = 1'b1;
        state_d    = FILL;
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = FILL;
      end
    endcase
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_bit     = out_bit_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.block_start = block_start_q;
  assign bus.block_end   = block_end_q;
endmodule

// File: tb/tb_turbo_encoder_tx.sv
// Directed and randomized-gap bench for turbo_encoder_tx with K = 8, ILV_STEP = 3.
module tb_turbo_encoder_tx;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  turbo_encoder_tx_if bus();

  turbo_encoder_tx #(.K(8), .ILV_STEP(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [23:0] ALL_V  = 24'hFFFFFF;
  localparam logic [71:0] FLAGS  = {24'h000001, 24'h800000, 24'h000000};
  localparam logic [2:0]  POST   = 3'b001;

  // Interleave triplets: bit 3i = sys, 3i+1 = p1, 3i+2 = p2.
  function automatic logic [23:0] pack(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [23:0] r;
    for (int i = 0; i < 8; i++) begin
      r[3*i]   = s[i];
      r[3*i+1] = a[i];
      r[3*i+2] = b[i];
    end
    return r;
  endfunction

  // Reference: feedback 1+D+D^2, feedforward 1+D^2, pi(i) = 3i mod 8.
  function automatic logic [23:0] ref_stream(input logic [7:0] d);
    logic [1:0] m1, m2;
    logic [7:0] pa, pb, di;
    logic fb;
    m1 = 2'b00;
    m2 = 2'b00;
    for (int i = 0; i < 8; i++) di[i] = d[(3 * i) % 8];
    for (int i = 0; i < 8; i++) begin
      fb = d[i] ^ m1[0] ^ m1[1];
      pa[i] = fb ^ m1[1];
      m1 = {m1[0], fb};
      fb = di[i] ^ m2[0] ^ m2[1];
      pb[i] = fb ^ m2[1];
      m2 = {m2[0], fb};
    end
    return pack(d, pa, pb);
  endfunction

  task automatic send_block(input logic [7:0] d, input int max_gap);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (max_gap > 0 && $urandom_range(0, max_gap) != 0) begin
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_bit   = d[k];
        if (bus.in_ready) k++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (k < 8) begin
      checks++;
      errors++;
      $display("FAIL send_block: accepted %0d bits, required 8", k);
    end
  endtask

  // Captures one 24-bit burst plus the cycle after it.
  task automatic collect(output logic [23:0] s, output logic [23:0] v, output logic [71:0] fl,
                         output logic [2:0] post, output bit to);
    int t;
    logic [23:0] st, en, rd;
    t = 0;
    to = 1'b0;
    s = '0; v = '0; st = '0; en = '0; rd = '0; post = '0;
    @(negedge clk);
    while (!bus.out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      to = 1'b1;
    end else begin
      for (int n = 0; n < 24; n++) begin
        if (n > 0) @(negedge clk);
        s[n]  = bus.out_bit;
        v[n]  = bus.out_valid;
        st[n] = bus.block_start;
        en[n] = bus.block_end;
        rd[n] = bus.in_ready;
      end
      @(negedge clk);
      post = {bus.out_valid, bus.out_bit, bus.in_ready};
    end
    fl = {st, en, rd};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_bit, bus.out_valid, bus.block_start, bus.block_end} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 10000",
               {bus.in_ready, bus.out_bit, bus.out_valid, bus.block_start, bus.block_end});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zeros;
    logic [23:0] s, v; logic [71:0] fl; logic [2:0] post; bit to;
    send_block(8'h00, 0);
    collect(s, v, fl, post, to);
    checks++;
    if (to) begin errors++; $display("FAIL zeros_timeout: no out_valid within 200 cycles"); end
    checks++;
    if (s !== 24'h0) begin errors++; $display("FAIL zeros_stream: got %h required 000000", s); end
    checks++;
    if (v !== ALL_V) begin errors++; $display("FAIL zeros_valid: got %h required %h", v, ALL_V); end
    checks++;
    if (fl !== FLAGS) begin errors++; $display("FAIL zeros_flags: got %h required %h", fl, FLAGS); end
    checks++;
    if (post !== POST) begin errors++; $display("FAIL zeros_post: got %b required %b", post, POST); end
  endtask

  task automatic test_impulse0;
    logic [23:0] s, v, e; logic [71:0] fl; logic [2:0] post; bit to;
    e = pack(8'b00000001, 8'b10110111, 8'b10110111);
    send_block(8'b00000001, 0);
    collect(s, v, fl, post, to);
    checks++;
    if (s !== e || to) begin errors++; $display("FAIL impulse0_stream: got %h required %h", s, e); end
    checks++;
    if (fl !== FLAGS) begin errors++; $display("FAIL impulse0_flags: got %h required %h", fl, FLAGS); end
    checks++;
    if (post !== POST) begin errors++; $display("FAIL impulse0_post: got %b required %b", post, POST); end
  endtask

  task automatic test_impulse1;
    logic [23:0] s, v, e; logic [71:0] fl; logic [2:0] post; bit to;
    e = pack(8'b00000010, 8'b01101110, 8'b10111000);
    send_block(8'b00000010, 0);
    collect(s, v, fl, post, to);
    checks++;
    if (s !== e || to) begin errors++; $display("FAIL impulse1_stream: got %h required %h", s, e); end
    checks++;
    if (v !== ALL_V) begin errors++; $display("FAIL impulse1_valid: got %h required %h", v, ALL_V); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] seq;
    logic [23:0] sa, va, sb, vb, ea, eb; logic [71:0] fa, fb; logic [2:0] pa, pb; bit ta, tb;
    seq = {8'b00000010, 8'b00000001};
    ea = pack(8'b00000001, 8'b10110111, 8'b10110111);
    eb = pack(8'b00000010, 8'b01101110, 8'b10111000);
    fork
      begin
        int k;
        int guard;
        logic tog;
        k = 0; guard = 0; tog = 1'b1;
        while (k < 16 && guard < 400) begin
          @(negedge clk);
          guard++;
          bus.in_valid = 1'b1;
          if (bus.in_ready) begin
            bus.in_bit = seq[k];
            k++;
          end else begin
            bus.in_bit = tog;
            tog = ~tog;
          end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        collect(sa, va, fa, pa, ta);
        collect(sb, vb, fb, pb, tb);
      end
    join
    checks++;
    if (sa !== ea || ta) begin errors++; $display("FAIL b2b_first: got %h required %h", sa, ea); end
    checks++;
    if (sb !== eb || tb) begin errors++; $display("FAIL b2b_second: got %h required %h", sb, eb); end
    checks++;
    if (fb !== FLAGS) begin errors++; $display("FAIL b2b_flags: got %h required %h", fb, FLAGS); end
  endtask

  task automatic test_reset_mid_enc;
    logic [23:0] s, v, e; logic [71:0] fl; logic [2:0] post; bit to;
    int t;
    e = pack(8'b00000001, 8'b10110111, 8'b10110111);
    send_block(8'hFF, 0);
    t = 0;
    while (!bus.out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: out_valid %b required 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_bit, bus.out_valid, bus.block_start, bus.block_end} !== 5'b10000) begin
      errors++;
      $display("FAIL midrst_outputs: got %b required 10000",
               {bus.in_ready, bus.out_bit, bus.out_valid, bus.block_start, bus.block_end});
    end
    @(negedge clk);
    rst = 1'b0;
    send_block(8'b00000001, 0);
    collect(s, v, fl, post, to);
    checks++;
    if (s !== e || to) begin errors++; $display("FAIL midrst_stream: got %h required %h", s, e); end
    checks++;
    if (fl !== FLAGS) begin errors++; $display("FAIL midrst_flags: got %h required %h", fl, FLAGS); end
  endtask

  task automatic test_random_gaps;
    logic [7:0] d;
    logic [23:0] s, v, e; logic [71:0] fl; logic [2:0] post; bit to;
    for (int b = 0; b < 100; b++) begin
      d = 8'($urandom);
      e = ref_stream(d);
      send_block(d, 3);
      collect(s, v, fl, post, to);
      checks++;
      if (s !== e || to) begin
        errors++;
        $display("FAIL random_stream[%0d]: d=%h got %h required %h", b, d, s, e);
      end
      checks++;
      if (v !== ALL_V || fl !== FLAGS || post !== POST) begin
        errors++;
        $display("FAIL random_framing[%0d]: valid %h flags %h post %b required %h %h %b",
                 b, v, fl, post, ALL_V, FLAGS, POST);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    test_reset();
    test_zeros();
    test_impulse0();
    test_impulse1();
    test_back_to_back();
    test_reset_mid_enc();
    test_random_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
